hazard_ctrl: RTL

Parametrised hazard and forwarding controller for the miniRV pipeline. It sits beside the ID stage. It picks forwarding sources for rs1/rs2 from N_FWD downstream write-back stages, and stalls ID on load-use hazards. It tracks one outstanding multi-cycle (MUL/DIV) operation in a registered scoreboard and generates branch flushes. It also keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding-source selection, load-use / long-op / EX-start
// stall detection, branch flush generation, and a one-entry scoreboard for
// the outstanding multi-cycle (MUL/DIV) operation. Sits beside ID.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int N_FWD      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SW         = $clog2(N_FWD + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs1,
    input  logic [REG_AW-1:0]       id_rs2,
    input  logic                    id_rs1_used,
    input  logic                    id_rs2_used,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_we,
    input  logic                    id_is_long,
    input  logic [N_FWD*REG_AW-1:0] fwd_rd,
    input  logic [N_FWD-1:0]        fwd_we,
    input  logic [N_FWD-1:0]        fwd_is_load,
    input  logic                    ex_long_start,
    input  logic [REG_AW-1:0]       ex_long_rd,
    input  logic                    long_done,
    input  logic                    br_taken,
    output logic [SW-1:0]           rs1_sel,
    output logic [SW-1:0]           rs2_sel,
    output logic                    stall_if,
    output logic                    flush_if_id,
    output logic                    flush_id_ex,
    output logic                    long_pending,
    output logic [31:0]             stall_cnt
);

    localparam logic [SW-1:0] SEL_LONG = SW'(N_FWD + 1);

    logic              long_pending_reg, long_pending_next;
    logic [REG_AW-1:0] long_rd_reg, long_rd_next;
    logic [31:0]       stall_cnt_reg, stall_cnt_next;

    logic [N_FWD-1:0]  rs1_match;
    logic [N_FWD-1:0]  rs2_match;
    logic [N_FWD-1:0]  load_early;   // stage holds a load whose data is not yet forwardable

    logic load_use_rs1, load_use_rs2;
    logic long_busy, long_raw, long_waw, long_hazard;
    logic ex_start_hazard;
    logic stall;

    // Per-stage match and "too-early load" vectors; x0 never matches.
    genvar gi;
    generate
        for (gi = 0; gi < N_FWD; gi++) begin : g_stage
            logic [REG_AW-1:0] stage_rd;
            assign stage_rd      = fwd_rd[gi*REG_AW +: REG_AW];
            assign rs1_match[gi] = fwd_we[gi] && (stage_rd == id_rs1) && (id_rs1 != '0);
            assign rs2_match[gi] = fwd_we[gi] && (stage_rd == id_rs2) && (id_rs2 != '0);
            if ((gi + 1) < LOAD_STAGE) begin : g_early
                assign load_early[gi] = fwd_is_load[gi];
            end else begin : g_late
                assign load_early[gi] = 1'b0;
            end
        end
    endgenerate

    // Select for one source: long unit first, then youngest matching stage, else regfile.
    function automatic logic [SW-1:0] pick_sel(
        input logic [REG_AW-1:0] rs,
        input logic              used,
        input logic [N_FWD-1:0]  match
    );
        logic [SW-1:0] sel;
        sel = '0;
        for (int k = N_FWD; k >= 1; k--) begin
            if (match[k-1]) sel = SW'(k);
        end
        if (long_done && (long_rd_reg == rs) && (rs != '0)) sel = SEL_LONG;
        if (!used) sel = '0;
        return sel;
    endfunction

    // True when the chosen source is a stage whose load data is not yet available.
    function automatic logic is_load_use(
        input logic [SW-1:0]    sel,
        input logic [N_FWD-1:0] early
    );
        logic hit;
        hit = 1'b0;
        for (int k = 1; k <= N_FWD; k++) begin
            if ((sel == SW'(k)) && early[k-1]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Forwarding selects, hazard detection, and stall/flush outputs.
    always_comb begin
        rs1_sel      = pick_sel(id_rs1, id_rs1_used, rs1_match);
        rs2_sel      = pick_sel(id_rs2, id_rs2_used, rs2_match);
        load_use_rs1 = is_load_use(rs1_sel, load_early);
        load_use_rs2 = is_load_use(rs2_sel, load_early);

        long_busy   = long_pending_reg && !long_done;
        long_raw    = (id_rs1_used && (id_rs1 != '0) && (id_rs1 == long_rd_reg)) ||
                      (id_rs2_used && (id_rs2 != '0) && (id_rs2 == long_rd_reg));
        long_waw    = id_we && (id_rd != '0) && (id_rd == long_rd_reg);
        long_hazard = long_busy && (long_raw || long_waw || id_is_long);

        ex_start_hazard = ex_long_start && (ex_long_rd != '0) &&
                          ((id_rs1_used && (id_rs1 == ex_long_rd)) ||
                           (id_rs2_used && (id_rs2 == ex_long_rd)));

        stall = id_valid && (load_use_rs1 || load_use_rs2 || long_hazard || ex_start_hazard);

        // A taken branch kills the ID instruction anyway, so it wins over a stall.
        stall_if    = stall && !br_taken;
        flush_if_id = br_taken;
        flush_id_ex = stall || br_taken;
    end

    // Scoreboard and stall-counter next state; a new start wins over a completion.
    always_comb begin
        long_pending_next = long_pending_reg;
        long_rd_next      = long_rd_reg;
        if (ex_long_start) begin
            long_pending_next = 1'b1;
            long_rd_next      = ex_long_rd;
        end else if (long_done) begin
            long_pending_next = 1'b0;
        end
        stall_cnt_next = stall_if ? (stall_cnt_reg + 32'd1) : stall_cnt_reg;
    end

    // State registers with synchronous reset; reset abandons any tracked long op.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_pending_reg <= 1'b0;
            long_rd_reg      <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            long_pending_reg <= long_pending_next;
            long_rd_reg      <= long_rd_next;
            stall_cnt_reg    <= stall_cnt_next;
        end
    end

    assign long_pending = long_pending_reg;
    assign stall_cnt    = stall_cnt_reg;

endmodule
